// File: rtl/muldiv_pkg.sv
// Shared types and op-decoding helpers for the RV32M iterative multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  function automatic logic is_div(input muldiv_op_e op);
    return op inside {DIV, DIVU, REM, REMU};
  endfunction

  function automatic logic is_signed_a(input muldiv_op_e op);
    return op inside {MULH, MULHSU, DIV, REM};
  endfunction

  function automatic logic is_signed_b(input muldiv_op_e op);
    return op inside {MULH, DIV, REM};
  endfunction

endpackage

// File: rtl/exe_muldiv_unit.sv
// Fixed-latency iterative RV32M multiply/divide: one radix-2 step per cycle over
// unsigned magnitudes in a shared 2*DATA_WIDTH accumulator, sign-corrected at the end.
module exe_muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  start_i,
  input  logic [2:0]            op_i,
  input  logic [DATA_WIDTH-1:0] a_i,
  input  logic [DATA_WIDTH-1:0] b_i,
  output logic [DATA_WIDTH-1:0] result_o,
  output logic                  done_o,
  output logic                  busy_o,
  output logic                  stall_o
);

  localparam int W = DATA_WIDTH;

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [W-1:0]    mcand_q, mcand_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    result_q, result_d;
  logic [CNT_WIDTH-1:0] count_q, count_d;
  logic            neg_q, neg_d;
  logic            rem_neg_q, rem_neg_d;
  logic            div_zero_q, div_zero_d;

  muldiv_op_e      op_in;
  logic            sign_a, sign_b;
  logic [W-1:0]    a_mag, b_mag;
  logic [W:0]      sum, rem_shift, diff;
  logic [2*W-1:0]  step, prod;
  logic [W-1:0]    quot, rem, final_res;

  always_comb begin
    op_in  = muldiv_op_e'(op_i);
    sign_a = is_signed_a(op_in) & a_i[W-1];
    sign_b = is_signed_b(op_in) & b_i[W-1];
    a_mag  = sign_a ? -a_i : a_i;
    b_mag  = sign_b ? -b_i : b_i;

    // Multiply: conditional add into the high half, then shift the pair right.
    // Divide: shift the remainder/quotient pair left, trial-subtract the divisor.
    sum       = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? mcand_q : '0)};
    rem_shift = acc_q[2*W-1:W-1];
    diff      = rem_shift - {1'b0, mcand_q};
    if (is_div(op_q)) begin
      step = diff[W] ? {rem_shift[W-1:0], acc_q[W-2:0], 1'b0}
                     : {diff[W-1:0], acc_q[W-2:0], 1'b1};
    end else begin
      step = {sum, acc_q[W-1:1]};
    end

    prod = neg_q ? -step : step;
    quot = neg_q ? -step[W-1:0] : step[W-1:0];
    rem  = rem_neg_q ? -step[2*W-1:W] : step[2*W-1:W];

    // Signed overflow (min / -1) falls out of the magnitude path naturally;
    // only divide-by-zero needs an override.
    case (op_q)
      MUL:         final_res = prod[W-1:0];
      MULH, MULHSU,
      MULHU:       final_res = prod[2*W-1:W];
      DIV, DIVU:   final_res = div_zero_q ? '1 : quot;
      REM, REMU:   final_res = div_zero_q ? a_q : rem;
      default:     final_res = '0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    acc_d      = acc_q;
    mcand_d    = mcand_q;
    a_d        = a_q;
    result_d   = result_q;
    count_d    = count_q;
    neg_d      = neg_q;
    rem_neg_d  = rem_neg_q;
    div_zero_d = div_zero_q;

    case (state_q)
      IDLE: begin
        if (start_i && !flush_i) begin
          state_d    = CALC;
          op_d       = op_in;
          acc_d      = {{W{1'b0}}, a_mag};
          mcand_d    = b_mag;
          a_d        = a_i;
          count_d    = '0;
          div_zero_d = is_div(op_in) && (b_i == '0);
          neg_d      = (sign_a ^ sign_b) && !(is_div(op_in) && (b_i == '0));
          rem_neg_d  = sign_a;
        end
      end
      CALC: begin
        if (flush_i) begin
          state_d = IDLE;
        end else begin
          acc_d   = step;
          count_d = count_q + CNT_WIDTH'(1);
          if (count_q == CNT_WIDTH'(W - 1)) begin
            result_d = final_res;
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= MUL;
      acc_q      <= '0;
      mcand_q    <= '0;
      a_q        <= '0;
      result_q   <= '0;
      count_q    <= '0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      div_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      mcand_q    <= mcand_d;
      a_q        <= a_d;
      result_q   <= result_d;
      count_q    <= count_d;
      neg_q      <= neg_d;
      rem_neg_q  <= rem_neg_d;
      div_zero_q <= div_zero_d;
    end
  end

  assign result_o = result_q;
  assign done_o   = (state_q == DONE);
  assign busy_o   = (state_q != IDLE);
  assign stall_o  = ((state_q == IDLE) && start_i && !flush_i) || (state_q == CALC);

endmodule
